dmem_ctrl: RTL and testbench

- Parametrised RV32 data-memory controller; successor to the single-cycle data memory.
- Sits between the execute/LSU stage and a word-organised RAM.
- Adds byte/half/word loads and stores with sign/zero extension, a valid/ready request channel, registered responses, misalignment and range error reporting, and a hardware clear sequencer after reset.

---
 rtl/dmem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// RV32 data-memory controller: byte/half/word loads and stores over a word RAM,
// valid/ready request channel, registered one-cycle responses, and a post-reset clear sequencer.
module dmem_ctrl #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            busy
);

    localparam int NB = XLEN / 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          state_r, state_s;
    logic [AW-1:0]   cnt_r, cnt_s;
    logic [XLEN-1:0] mem [DEPTH];

    logic            req_ready_s;
    logic            accept_s;
    logic [AW-1:0]   word_idx_s;
    logic [1:0]      lane_s;
    logic            oor_s, misal_s, illegal_s, err_s;
    logic            store_s, clr_we_s;
    logic [NB-1:0]   be_s;
    logic [XLEN-1:0] wdata_s;
    logic [XLEN-1:0] rd_word_s, lane_data_s, load_s;

    logic            rsp_valid_r, rsp_err_r;
    logic [XLEN-1:0] rsp_rdata_r;

    // Ready only in RUN; reset masks it combinationally so the port reads 0 while rst is held.
    assign req_ready_s = (state_r == ST_RUN) && !rst;
    assign req_ready   = req_ready_s;
    assign busy        = !req_ready_s;
    assign accept_s    = req_valid && req_ready_s;
    assign clr_we_s    = (state_r == ST_CLEAR) && !rst;

    assign word_idx_s  = req_addr[AW+1:2];
    assign lane_s      = req_addr[1:0];
    assign oor_s       = |req_addr[XLEN-1:AW+2];

    // State register and clear counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_CLEAR;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state: walk the clear counter over every word, then run forever.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_CLEAR: begin
                cnt_s = cnt_r + AW'(1);
                if (cnt_r == AW'(DEPTH - 1)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                state_s = ST_RUN;
                cnt_s   = cnt_r;
            end
            default: begin
                state_s = ST_CLEAR;
                cnt_s   = '0;
            end
        endcase
    end

    // Request decode: misalignment and illegal funct3 checks.
    always_comb begin
        misal_s   = 1'b0;
        illegal_s = 1'b0;
        case (req_funct3[1:0])
            2'd1:    misal_s = req_addr[0];
            2'd2:    misal_s = |req_addr[1:0];
            default: misal_s = 1'b0;
        endcase
        if (req_we) begin
            illegal_s = (req_funct3 > 3'd2);
        end else begin
            illegal_s = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'd6);
        end
    end

    assign err_s   = oor_s || misal_s || illegal_s;
    assign store_s = accept_s && req_we && !err_s;

    // Byte enables and lane-replicated store data.
    always_comb begin
        be_s    = '0;
        wdata_s = '0;
        case (req_funct3[1:0])
            2'd0: begin
                be_s    = NB'(1) << lane_s;
                wdata_s = {NB{req_wdata[7:0]}};
            end
            2'd1: begin
                be_s    = req_addr[1] ? NB'(12) : NB'(3);
                wdata_s = {(NB/2){req_wdata[15:0]}};
            end
            2'd2: begin
                be_s    = '1;
                wdata_s = req_wdata;
            end
            default: begin
                be_s    = '0;
                wdata_s = '0;
            end
        endcase
    end

    // Single write port shared by the clear sequencer and lane-masked stores.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem[cnt_r] <= '0;
        end else if (store_s) begin
            for (int b = 0; b < NB; b++) begin
                if (be_s[b]) begin
                    mem[word_idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
                end
            end
        end
    end

    assign rd_word_s   = mem[word_idx_s];
    assign lane_data_s = rd_word_s >> {lane_s, 3'b000};

    // Load lane extraction with sign/zero extension.
    always_comb begin
        load_s = '0;
        case (req_funct3)
            3'd0:    load_s = {{(XLEN-8){lane_data_s[7]}}, lane_data_s[7:0]};
            3'd1:    load_s = {{(XLEN-16){lane_data_s[15]}}, lane_data_s[15:0]};
            3'd2:    load_s = lane_data_s;
            3'd4:    load_s = {{(XLEN-8){1'b0}}, lane_data_s[7:0]};
            3'd5:    load_s = {{(XLEN-16){1'b0}}, lane_data_s[15:0]};
            default: load_s = '0;
        endcase
    end

    // Response register: one pulse per accepted request, data zeroed for stores and errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            rsp_valid_r <= accept_s;
            rsp_err_r   <= accept_s && err_s;
            rsp_rdata_r <= (accept_s && !err_s && !req_we) ? load_s : '0;
        end
    end

    assign rsp_valid = rsp_valid_r && !rst;
    assign rsp_err   = rsp_err_r && !rst;
    assign rsp_rdata = rst ? '0 : rsp_rdata_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl (DEPTH=16): directed plan cases plus random traffic
// checked against a byte-level reference model of the memory.
module tb_dmem_ctrl;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic            clk;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic            busy;

    dmem_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] mm [DEPTH];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-addressed memory semantics straight from the RV32 rules.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int          idx;
        int          lane;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        err = 1'b0;
        rd  = 32'h0;
        if (addr >= 32'(DEPTH * 4)) err = 1'b1;
        if (we && f3 > 3'd2) err = 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) err = 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) err = 1'b1;
        if (f3 == 3'd2 && addr[1:0] != 2'd0) err = 1'b1;
        if (err) return;
        idx  = int'(addr / 4);
        lane = int'(addr % 4);
        w    = mm[idx];
        if (we) begin
            case (f3)
                3'd0:    w[lane*8 +: 8]  = wd[7:0];
                3'd1:    w[lane*8 +: 16] = wd[15:0];
                default: w = wd;
            endcase
            mm[idx] = w;
        end else begin
            b = 8'(w >> (8 * lane));
            h = 16'(w >> (8 * lane));
            case (f3)
                3'd0:    rd = {{24{b[7]}}, b};
                3'd1:    rd = {{16{h[15]}}, h};
                3'd4:    rd = {24'h0, b};
                3'd5:    rd = {16'h0, h};
                default: rd = w;
            endcase
        end
    endtask

    // Present one request for one cycle; if accepted, queue the expected response.
    task automatic send_x(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic use_const,
                          input logic [31:0] xrd, input logic xerr);
        logic        e;
        logic [31:0] r;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        if (req_ready) begin
            model(we, f3, addr, wd, e, r);
            if (use_const) begin
                e = xerr;
                r = xrd;
            end
            q.push_back('{e, r, cyc + 1});
        end
        @(negedge clk);
    endtask

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        send_x(we, f3, addr, wd, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        req_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
        repeat (n) begin
            #1;
            chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
            chk("rst_busy", {31'h0, busy}, 32'h1);
            chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
            chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
            chk("rst_rsp_rdata", rsp_rdata, 32'h0);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    // Count busy cycles after reset release (start = cycles already spent) until ready.
    task automatic wait_clear(input int start);
        int n;
        n = start;
        req_valid = 1'b0;
        #1;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("clear_cycles", 32'(n), 32'(DEPTH));
        chk("ready_after_clear", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
    endtask

    // Monitor: pop and compare on every response pulse; flag stray or missing pulses.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 want no response (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("rsp_latency", 32'(cyc), 32'(mon_e.cyc));
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                end
            end else if (rst === 1'b0) begin
                chk("idle_rdata", rsp_rdata, 32'h0);
                chk("idle_err", {31'h0, rsp_err}, 32'h0);
            end
            if (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                failures++;
                $display("FAIL rsp_missing: got no rsp_valid want response due cycle %0d (now %0d)",
                         q[0].cyc, cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [31:0] a;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        @(negedge clk);

        // Reset clear and first load
        do_reset(2);
        wait_clear(0);
        send_x(1'b0, 3'd2, 32'h3C, 32'h0, 1'b1, 32'h0000_0000, 1'b0);
        idle(1);

        // Sub-word stores merge into one word
        send(1'b1, 3'd2, 32'h8, 32'h1122_3344);
        send(1'b1, 3'd0, 32'h9, 32'h0000_00AA);
        send(1'b1, 3'd1, 32'hA, 32'h0000_BEEF);
        send_x(1'b0, 3'd2, 32'h8, 32'h0, 1'b1, 32'hBEEF_AA44, 1'b0);
        idle(1);

        // Sign and zero extension
        send(1'b1, 3'd2, 32'h4, 32'h80FF_7F01);
        send_x(1'b0, 3'd0, 32'h7, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0);
        send_x(1'b0, 3'd4, 32'h7, 32'h0, 1'b1, 32'h0000_0080, 1'b0);
        send_x(1'b0, 3'd1, 32'h6, 32'h0, 1'b1, 32'hFFFF_80FF, 1'b0);
        send_x(1'b0, 3'd5, 32'h4, 32'h0, 1'b1, 32'h0000_7F01, 1'b0);
        idle(1);

        // Errors leave memory untouched
        send_x(1'b0, 3'd2, 32'h6, 32'h0, 1'b1, 32'h0, 1'b1);
        send_x(1'b1, 3'd1, 32'h5, 32'h1234_5678, 1'b1, 32'h0, 1'b1);
        send_x(1'b0, 3'd2, 32'h4, 32'h0, 1'b1, 32'h80FF_7F01, 1'b0);
        send_x(1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 1'b1, 32'h0, 1'b1);
        send_x(1'b0, 3'd3, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
        send_x(1'b1, 3'd4, 32'h4, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1);
        send_x(1'b0, 3'd2, 32'h4, 32'h0, 1'b1, 32'h80FF_7F01, 1'b0);
        idle(1);

        // Back-to-back store then load of the same word
        send(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        send_x(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        idle(2);

        // Reset mid-stream drops the pending response and re-clears memory
        send(1'b1, 3'd2, 32'h20, 32'h1234_5678);
        idle(1);
        send(1'b0, 3'd2, 32'h20, 32'h0);
        do_reset(2);
        wait_clear(0);
        send_x(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 32'h0000_0000, 1'b0);
        idle(1);

        // Reset during clear restarts it; requests held while not ready are ignored
        send(1'b1, 3'd2, 32'h3C, 32'h5555_5555);
        idle(1);
        do_reset(1);
        send(1'b1, 3'd2, 32'h3C, 32'hFFFF_FFFF);
        send(1'b1, 3'd2, 32'h3C, 32'hFFFF_FFFF);
        send(1'b1, 3'd2, 32'h3C, 32'hFFFF_FFFF);
        do_reset(1);
        send(1'b1, 3'd0, 32'h3D, 32'h0000_00FF);
        send(1'b1, 3'd0, 32'h3D, 32'h0000_00FF);
        send(1'b1, 3'd0, 32'h3D, 32'h0000_00FF);
        wait_clear(3);
        send_x(1'b0, 3'd2, 32'h3C, 32'h0, 1'b1, 32'h0000_0000, 1'b0);
        idle(1);

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_0100;
                else a = 32'($urandom_range(0, DEPTH * 4 + 7));
                send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            end
        end
        for (int i = 0; i < DEPTH; i++) send(1'b0, 3'd2, 32'(i * 4), 32'h0);
        idle(3);
        chk("queue_drain", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
